// File: rtl/mul_seq_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply unit:
// op encodings (funct3[1:0]), FSM states and operand signedness helpers.
package mul_seq_unit_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_CALC,
        S_FIXLO,
        S_FIXHI,
        S_DONE
    } state_e;

    function automatic logic rs1_signed(input mul_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic rs2_signed(input mul_op_e op);
        return op == OP_MULH;
    endfunction

endpackage

// File: rtl/cla_xlen.sv
// XLEN-bit adder built from 4-bit carry-lookahead slices, carries rippled
// between slices. Shared by the multiply unit and reusable by the ALU.
module cla_xlen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] term1_i,
    input  logic [XLEN-1:0] term2_i,
    input  logic            carry_i,
    output logic [XLEN-1:0] result_o,
    output logic            carry_o
);

    localparam int NS = XLEN / 4;

    logic [NS:0] cy;

    assign cy[0]   = carry_i;
    assign carry_o = cy[NS];

    for (genvar i = 0; i < NS; i++) begin : g_slice
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;

        assign p = term1_i[4*i +: 4] ^ term2_i[4*i +: 4];
        assign g = term1_i[4*i +: 4] & term2_i[4*i +: 4];

        assign c[0] = cy[i];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);

        assign cy[i+1] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                       | (p[3] & p[2] & p[1] & g[0])
                       | (p[3] & p[2] & p[1] & p[0] & c[0]);

        assign result_o[4*i +: 4] = p ^ c;
    end

endmodule

// File: rtl/mul_seq_unit.sv
// Iterative shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU) sharing
// a single XLEN-bit CLA adder for negation, accumulation and fix-up.
module mul_seq_unit
    import mul_seq_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN);

    state_e          state;
    state_e          state_nx;
    mul_op_e         op;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mcand;
    logic            sgn1;
    logic            sgn2;
    logic            fix_c;
    logic            neg;

    logic [XLEN-1:0] add_a;
    logic [XLEN-1:0] add_b;
    logic            add_ci;
    logic [XLEN-1:0] sum;
    logic            add_c;

    assign neg     = sgn1 ^ sgn2;
    assign ready_o = (state == S_IDLE);
    assign busy_o  = (state != S_IDLE);

    cla_xlen #(.XLEN(XLEN)) u_add (
        .term1_i  (add_a),
        .term2_i  (add_b),
        .carry_i  (add_ci),
        .result_o (sum),
        .carry_o  (add_c)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (valid_i) state_nx = S_PREP;
            S_PREP:  state_nx = S_CALC;
            S_CALC:  if (cnt == '0) state_nx = S_FIXLO;
            S_FIXLO: state_nx = S_FIXHI;
            S_FIXHI: state_nx = S_DONE;
            S_DONE:  if (ready_i) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // A negative multiplicand is added as ~mcand + 1, i.e. its magnitude,
    // so only the multiplier needs an explicit negation in PREP.
    always_comb begin
        add_a  = '0;
        add_b  = '0;
        add_ci = 1'b0;
        unique case (state)
            S_PREP: begin
                add_a  = ~lo;
                add_ci = 1'b1;
            end
            S_CALC: begin
                add_a  = hi;
                add_b  = sgn1 ? ~mcand : mcand;
                add_ci = sgn1;
            end
            S_FIXLO: begin
                add_a  = ~lo;
                add_ci = 1'b1;
            end
            S_FIXHI: begin
                add_a  = ~hi;
                add_ci = fix_c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            op       <= OP_MUL;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mcand    <= '0;
            sgn1     <= 1'b0;
            sgn2     <= 1'b0;
            fix_c    <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        op    <= mul_op_e'(op_i);
                        mcand <= rs1_i;
                        lo    <= rs2_i;
                        sgn1  <= rs1_signed(mul_op_e'(op_i)) & rs1_i[XLEN-1];
                        sgn2  <= rs2_signed(mul_op_e'(op_i)) & rs2_i[XLEN-1];
                    end
                end
                S_PREP: begin
                    hi  <= '0;
                    cnt <= CW'(XLEN - 1);
                    if (sgn2) lo <= sum;
                end
                S_CALC: begin
                    cnt <= cnt - 1'b1;
                    if (lo[0]) {hi, lo} <= {add_c, sum, lo[XLEN-1:1]};
                    else       {hi, lo} <= {1'b0, hi, lo[XLEN-1:1]};
                end
                S_FIXLO: begin
                    if (neg) begin
                        lo    <= sum;
                        fix_c <= add_c;
                    end
                end
                S_FIXHI: begin
                    if (neg) hi <= sum;
                    result_o <= (op == OP_MUL) ? lo : (neg ? sum : hi);
                    valid_o  <= 1'b1;
                end
                S_DONE: begin
                    if (ready_i) valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Bench for mul_seq_unit: directed RV32M cases, backpressure, mid-op reset
// and randomized operations against a 64-bit arithmetic reference.
module tb_mul_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        rdy_out;
    logic        v_out;
    logic        busy;
    logic [31:0] res;

    int errors = 0;
    int checks = 0;

    int          age = -1;
    bit          mvalid = 1'b0;
    logic [31:0] mres = '0;
    bit          en = 1'b0;

    mul_seq_unit #(.XLEN(32)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (v_in),
        .ready_o  (rdy_out),
        .op_i     (op),
        .rs1_i    (a),
        .rs2_i    (b),
        .valid_o  (v_out),
        .ready_i  (rdy_in),
        .result_o (res),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
        logic [63:0] xs, xu, ys, yu, p;
        xs = {{32{x[31]}}, x};
        xu = {32'b0, x};
        ys = {{32{y[31]}}, y};
        yu = {32'b0, y};
        case (o)
            2'd0:    p = xu * yu;
            2'd1:    p = xs * ys;
            2'd2:    p = xs * yu;
            default: p = xu * yu;
        endcase
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Transaction-level model: accept when idle, result 35 edges later,
    // held until the consumer takes it; reset drops everything.
    always @(posedge clk) begin
        if (!rst_n) begin
            age    = -1;
            mvalid = 1'b0;
        end else if (age >= 0) begin
            age++;
            if (age == 35) begin
                age    = -1;
                mvalid = 1'b1;
            end
        end else if (mvalid) begin
            if (rdy_in) mvalid = 1'b0;
        end else if (v_in) begin
            age  = 0;
            mres = ref_mul(op, a, b);
        end
    end

    always @(negedge clk) begin
        if (en) begin
            check("busy_o", 32'(busy), 32'(age >= 0 || mvalid));
            check("ready_o", 32'(rdy_out), 32'(!(age >= 0 || mvalid)));
            check("valid_o", 32'(v_out), 32'(mvalid));
            if (mvalid) check("result_o", res, mres);
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp,
                          input int hold, input string tag);
        int n;
        n = 0;
        while (!rdy_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(rdy_out), 32'd1);
        v_in   = 1'b1;
        op     = o;
        a      = x;
        b      = y;
        rdy_in = 1'b0;
        @(negedge clk);
        v_in = 1'b0;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (v_out || n >= 60) break;
            v_in = 1'($urandom_range(0, 1));
            op   = 2'($urandom);
            a    = $urandom;
            b    = $urandom;
        end
        v_in = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'd35);
        check(tag, res, exp);
        repeat (hold) @(negedge clk);
        check({tag, "_held"}, res, exp);
        rdy_in = 1'b1;
        @(negedge clk);
        rdy_in = 1'b0;
        check({tag, "_released_valid"}, 32'(v_out), 32'd0);
        check({tag, "_released_ready"}, 32'(rdy_out), 32'd1);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;

        check("model_mul", ref_mul(2'd0, 32'd7, 32'd6), 32'h0000_002A);
        check("model_mulhu", ref_mul(2'd3, '1, '1), 32'hFFFF_FFFE);
        check("model_mulh_min", ref_mul(2'd1, 32'h8000_0000, 32'h8000_0000),
              32'h4000_0000);
        check("model_mulh_m1", ref_mul(2'd1, '1, '1), 32'h0000_0000);
        check("model_mulhsu", ref_mul(2'd2, '1, '1), 32'hFFFF_FFFF);

        repeat (2) @(negedge clk);
        check("rst_result", res, 32'h0);
        check("rst_valid", 32'(v_out), 32'd0);
        check("rst_ready", 32'(rdy_out), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        en    = 1'b1;

        run_op(2'd0, 32'd7, 32'd6, 32'h0000_002A, 0, "mul_7x6");
        run_op(2'd3, '1, '1, 32'hFFFF_FFFE, 1, "mulhu_ff");
        run_op(2'd0, '1, '1, 32'h0000_0001, 0, "mul_ff");
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2,
               "mulh_min");
        run_op(2'd1, '1, '1, 32'h0000_0000, 0, "mulh_m1");
        run_op(2'd2, '1, '1, 32'hFFFF_FFFF, 0, "mulhsu_ff");
        run_op(2'd1, 32'hFFFF_FFFB, 32'h0, 32'h0000_0000, 0, "mulh_zero");
        run_op(2'd0, 32'd12, 32'd13, 32'd156, 5, "backpressure");

        // Abort in the middle of CALC, then a fresh op must run cleanly.
        while (!rdy_out) @(negedge clk);
        v_in = 1'b1;
        op   = 2'd0;
        a    = 32'd123;
        b    = 32'd456;
        @(negedge clk);
        v_in = 1'b0;
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_valid", 32'(v_out), 32'd0);
        check("abort_ready", 32'(rdy_out), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        run_op(2'd0, 32'd3, 32'd5, 32'h0000_000F, 0, "mul_after_reset");

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            rx = pick();
            ry = pick();
            run_op(ro, rx, ry, ref_mul(ro, rx, ry), $urandom_range(0, 3),
                   "random");
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
